// File: rtl/game_fsm_lives.sv
// Top-level game controller: settle, start screen, play, post-hit invulnerability,
// pause and game over, with a configurable lives count for the HUD.
module game_fsm_lives #(
  parameter  int unsigned LIVES       = 3,
  parameter  int unsigned HIT_TIMEOUT = 50_000_000,
  parameter  int unsigned INIT_CYCLES = 16,
  localparam int unsigned LW          = $clog2(LIVES + 1),
  localparam int unsigned TW          = $clog2(HIT_TIMEOUT + 1),
  localparam int unsigned IW          = $clog2(INIT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          hard_reset_n,
  input  logic          start,
  input  logic          pause,
  input  logic          collision,
  output logic [2:0]    game_state,
  output logic          game_en,
  output logic          game_reset,
  output logic          invuln,
  output logic [LW-1:0] lives_left
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_IDLE     = 3'b001,
    ST_PLAYING  = 3'b010,
    ST_HIT      = 3'b011,
    ST_GAMEOVER = 3'b100,
    ST_PAUSED   = 3'b101
  } state_t;

  state_t        state;
  logic          start_reg;
  logic          pause_reg;
  logic [IW-1:0] init_cnt;
  logic [TW-1:0] hit_cnt;
  logic          start_pe;
  logic          pause_pe;

  // Rising-edge detect; a button held across reset release still yields one edge.
  assign start_pe = start & ~start_reg;
  assign pause_pe = pause & ~pause_reg;

  assign game_state = state;
  assign invuln     = (state == ST_HIT);

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state      <= ST_INIT;
      start_reg  <= 1'b0;
      pause_reg  <= 1'b0;
      init_cnt   <= '0;
      hit_cnt    <= '0;
      game_en    <= 1'b0;
      game_reset <= 1'b0;
      lives_left <= '0;
    end else begin
      start_reg  <= start;
      pause_reg  <= pause;
      game_reset <= 1'b0;

      case (state)
        ST_INIT: begin
          if (init_cnt == IW'(INIT_CYCLES - 1)) begin
            state    <= ST_IDLE;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end

        ST_IDLE: begin
          if (start_pe) begin
            state      <= ST_PLAYING;
            lives_left <= LW'(LIVES);
            game_en    <= 1'b1;
            game_reset <= 1'b1;
          end
        end

        // Collision outranks a same-cycle pause edge, which is dropped.
        ST_PLAYING: begin
          if (collision) begin
            if (lives_left == LW'(1)) begin
              state      <= ST_GAMEOVER;
              lives_left <= '0;
              game_en    <= 1'b0;
            end else begin
              state      <= ST_HIT;
              lives_left <= lives_left - LW'(1);
              hit_cnt    <= TW'(HIT_TIMEOUT - 1);
            end
          end else if (pause_pe) begin
            state   <= ST_PAUSED;
            game_en <= 1'b0;
          end
        end

        ST_HIT: begin
          if (hit_cnt == '0) begin
            state <= ST_PLAYING;
          end else begin
            hit_cnt <= hit_cnt - TW'(1);
          end
        end

        ST_PAUSED: begin
          if (pause_pe) begin
            state   <= ST_PLAYING;
            game_en <= 1'b1;
          end
        end

        ST_GAMEOVER: begin
          if (start_pe) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            game_reset <= 1'b1;
          end
        end

        default: begin
          state    <= ST_INIT;
          init_cnt <= '0;
          game_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_fsm_lives.sv
// Scoreboard bench for game_fsm_lives with LIVES=3, HIT_TIMEOUT=4, INIT_CYCLES=2.
module tb_game_fsm_lives;

  localparam int unsigned LIVES       = 3;
  localparam int unsigned HIT_TIMEOUT = 4;
  localparam int unsigned INIT_CYCLES = 2;
  localparam int unsigned LW          = $clog2(LIVES + 1);

  localparam logic [2:0] S_INIT = 3'b000;
  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_PLAY = 3'b010;
  localparam logic [2:0] S_HIT  = 3'b011;
  localparam logic [2:0] S_OVER = 3'b100;
  localparam logic [2:0] S_PAUS = 3'b101;

  typedef struct packed {
    logic [2:0]    st;
    logic          en;
    logic          rst;
    logic          inv;
    logic [LW-1:0] lives;
  } exp_t;

  logic          clk;
  logic          hard_reset_n;
  logic          start;
  logic          pause;
  logic          collision;
  logic [2:0]    game_state;
  logic          game_en;
  logic          game_reset;
  logic          invuln;
  logic [LW-1:0] lives_left;

  int unsigned n_cmp;
  int unsigned n_err;
  exp_t        exp_q[$];

  game_fsm_lives #(
    .LIVES      (LIVES),
    .HIT_TIMEOUT(HIT_TIMEOUT),
    .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clk         (clk),
    .hard_reset_n(hard_reset_n),
    .start       (start),
    .pause       (pause),
    .collision   (collision),
    .game_state  (game_state),
    .game_en     (game_en),
    .game_reset  (game_reset),
    .invuln      (invuln),
    .lives_left  (lives_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".state"}, 32'(game_state), 32'(e.st));
    check({tag, ".en"},    32'(game_en),    32'(e.en));
    check({tag, ".rst"},   32'(game_reset), 32'(e.rst));
    check({tag, ".inv"},   32'(invuln),     32'(e.inv));
    check({tag, ".lives"}, 32'(lives_left), 32'(e.lives));
  endtask

  // Called just after a rising edge: drive inputs for the next edge, queue the
  // expected post-edge outputs, then pop and compare once the edge has passed.
  task automatic step(input string tag, input logic s, input logic p, input logic c,
                      input logic [2:0] st, input logic en, input logic rst,
                      input logic inv, input int unsigned lv);
    exp_t e;
    exp_t got_e;
    start     = s;
    pause     = p;
    collision = c;
    e.st    = st;
    e.en    = en;
    e.rst   = rst;
    e.inv   = inv;
    e.lives = LW'(lv);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check({tag, ".qdepth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      got_e = exp_q.pop_front();
      check_outputs(tag, got_e);
    end
  endtask

  initial begin
    exp_t rst_e;
    n_cmp        = 0;
    n_err        = 0;
    hard_reset_n = 1'b0;
    start        = 1'b1;
    pause        = 1'b0;
    collision    = 1'b0;
    rst_e        = '0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", rst_e);

    // Release with start held: the edge lands in INIT and is discarded.
    hard_reset_n = 1'b1;
    step("settle0",   1, 0, 0, S_INIT, 0, 0, 0, 0);
    step("settle1",   1, 0, 0, S_IDLE, 0, 0, 0, 0);
    step("held_st",   1, 0, 0, S_IDLE, 0, 0, 0, 0);
    step("idle",      0, 0, 0, S_IDLE, 0, 0, 0, 0);
    step("start_pau", 1, 1, 0, S_PLAY, 1, 1, 0, 3);
    step("play0",     0, 0, 0, S_PLAY, 1, 0, 0, 3);
    step("play1",     0, 0, 0, S_PLAY, 1, 0, 0, 3);

    // Collision held for 10 cycles: 4 HIT, 1 PLAYING, 4 HIT, 1 PLAYING.
    for (int i = 0; i < 4; i++) step($sformatf("hitA%0d", i), 0, 0, 1, S_HIT, 1, 0, 1, 2);
    step("hitA_out",  0, 0, 1, S_PLAY, 1, 0, 0, 2);
    for (int i = 0; i < 4; i++) step($sformatf("hitB%0d", i), 0, 0, 1, S_HIT, 1, 0, 1, 1);
    step("hitB_out",  0, 0, 1, S_PLAY, 1, 0, 0, 1);
    step("play2",     0, 0, 0, S_PLAY, 1, 0, 0, 1);

    step("pause_in",  0, 1, 0, S_PAUS, 0, 0, 0, 1);
    step("paused0",   0, 0, 0, S_PAUS, 0, 0, 0, 1);
    step("paus_ign",  1, 0, 1, S_PAUS, 0, 0, 0, 1);
    step("paused1",   0, 0, 0, S_PAUS, 0, 0, 0, 1);
    step("pause_out", 0, 1, 0, S_PLAY, 1, 0, 0, 1);
    step("held_pau",  0, 1, 0, S_PLAY, 1, 0, 0, 1);
    step("play3",     0, 0, 0, S_PLAY, 1, 0, 0, 1);

    step("gameover",  0, 0, 1, S_OVER, 0, 0, 0, 0);
    step("over0",     0, 0, 0, S_OVER, 0, 0, 0, 0);
    step("over_col",  0, 0, 1, S_OVER, 0, 0, 0, 0);
    step("restart",   1, 0, 0, S_INIT, 0, 1, 0, 0);
    step("reinit1",   0, 0, 0, S_INIT, 0, 0, 0, 0);
    step("reidle0",   0, 0, 0, S_IDLE, 0, 0, 0, 0);
    step("reidle1",   0, 0, 0, S_IDLE, 0, 0, 0, 0);
    step("start2",    1, 0, 0, S_PLAY, 1, 1, 0, 3);
    step("play4",     0, 0, 0, S_PLAY, 1, 0, 0, 3);

    step("prio",      0, 1, 1, S_HIT,  1, 0, 1, 2);
    step("prio_hit",  0, 0, 0, S_HIT,  1, 0, 1, 2);

    // Asynchronous reset while in HIT, with no clock edge in between.
    #2;
    hard_reset_n = 1'b0;
    #1;
    check_outputs("async_rst", rst_e);

    @(posedge clk);
    #1;
    hard_reset_n = 1'b1;
    step("post_rst0", 0, 0, 0, S_INIT, 0, 0, 0, 0);
    step("post_rst1", 0, 0, 0, S_IDLE, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
